// File: rtl/spmv_mem_arbiter_pkg.sv
// Shared definitions for the SpMV PE memory-port arbiter: tag-field layout,
// sticky error bit positions and the channel-id width computation.
package spmv_mem_arbiter_pkg;

  // Load tag layout on req_mem_d_or_tag / rsp_mem_tag: {subtag, ch_id}
  localparam int unsigned CH_ID_LSB = 0;

  // Sticky error flag positions
  localparam int unsigned ERR_FULL = 0;  // push to a full channel FIFO
  localparam int unsigned ERR_TAG  = 1;  // response with ch_id >= NUM_CH

  // Channel-id width, never narrower than one bit
  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The subtag sits directly above the channel id
  function automatic int unsigned subtag_lsb(input int unsigned n);
    return CH_ID_LSB + ch_width(n);
  endfunction

endpackage

// File: rtl/spmv_mem_arbiter_rr.sv
// Channel grant selection for the memory-port arbiter. One-hot grant plus
// encoded index. Round-robin when SPMV_MEM_ARB_RR_EN is defined, otherwise a
// fixed lowest-index-wins priority encoder.
module spmv_mem_arbiter_rr
  import spmv_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);

`ifdef SPMV_MEM_ARB_RR_EN
  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] cand;

  // Search from last+1, wrapping NUM_CH-1 -> 0
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = CH_W'((32'(last_q) + off) % NUM_CH);
      if (!gnt_valid && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

  // Pointer moves only on a grant; reset leaves it so channel 0 is searched first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= CH_W'(NUM_CH - 1);
    end else if (gnt_valid) begin
      last_q <= gnt_idx;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Lowest requesting index wins
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!gnt_valid && req[k]) begin
        gnt[k]    = 1'b1;
        gnt_idx   = CH_W'(k);
        gnt_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spmv_mem_arbiter.sv
// SpMV PE memory-port arbiter: NUM_CH request FIFOs merged onto one memory
// port through a two-register pipeline, with tag-routed load responses.
// Build option: define SPMV_MEM_ARB_RR_EN for round-robin arbitration
// (default is fixed priority, channel 0 highest).
module spmv_mem_arbiter
  import spmv_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_W     = 48,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SUB_TAG_W  = 2,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     ch_req_ld,
  input  logic [NUM_CH-1:0]                     ch_req_st,
  input  logic [NUM_CH*ADDR_W-1:0]              ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0]              ch_req_d,
  input  logic [NUM_CH*SUB_TAG_W-1:0]           ch_req_subtag,
  output logic [NUM_CH-1:0]                     ch_req_almost_full,
  output logic                                  req_mem_ld,
  output logic                                  req_mem_st,
  output logic [ADDR_W-1:0]                     req_mem_addr,
  output logic [DATA_W-1:0]                     req_mem_d_or_tag,
  input  logic                                  req_mem_stall,
  input  logic                                  rsp_mem_push,
  input  logic [SUB_TAG_W+ch_width(NUM_CH)-1:0] rsp_mem_tag,
  input  logic [DATA_W-1:0]                     rsp_mem_q,
  output logic [NUM_CH-1:0]                     ch_rsp_push,
  output logic [SUB_TAG_W-1:0]                  ch_rsp_subtag,
  output logic [DATA_W-1:0]                     ch_rsp_q,
  output logic                                  busy,
  output logic [1:0]                            err
);

  localparam int unsigned CH_W       = ch_width(NUM_CH);
  localparam int unsigned SUBTAG_LSB = subtag_lsb(NUM_CH);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  // FIFO entry layout: {is_st, addr, data, subtag}
  localparam int unsigned ENT_W      = 1 + ADDR_W + DATA_W + SUB_TAG_W;

  logic [NUM_CH-1:0] nonempty, drop, gnt;
  logic [ENT_W-1:0]  head [NUM_CH];
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             af_q, push, wr_en;

    assign push        = ch_req_ld[i] | ch_req_st[i];
    assign wr_en       = push && (cnt_q != CNT_W'(FIFO_DEPTH));
    assign drop[i]     = push && (cnt_q == CNT_W'(FIFO_DEPTH));
    assign nonempty[i] = (cnt_q != '0);
    assign head[i]     = mem_q[rd_q];
    assign ch_req_almost_full[i] = af_q;

    // Occupancy after this edge; simultaneous push and pop leaves it unchanged
    always_comb begin
      cnt_d = cnt_q;
      if (wr_en && !gnt[i]) cnt_d = cnt_q + CNT_W'(1);
      else if (!wr_en && gnt[i]) cnt_d = cnt_q - CNT_W'(1);
    end

    // Entry storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wr_q] <= {ch_req_st[i], ch_req_addr[i*ADDR_W +: ADDR_W],
                        ch_req_d[i*DATA_W +: DATA_W], ch_req_subtag[i*SUB_TAG_W +: SUB_TAG_W]};
      end
    end

    // Pointers, count and registered almost-full
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        af_q  <= 1'b0;
      end else begin
        if (wr_en) wr_q <= wr_q + PTR_W'(1);
        if (gnt[i]) rd_q <= rd_q + PTR_W'(1);
        cnt_q <= cnt_d;
        af_q  <= (cnt_d >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
      end
    end
  end

  spmv_mem_arbiter_rr #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (nonempty & {NUM_CH{~req_mem_stall}}),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  logic              s1_valid_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [ENT_W-1:0]  s1_ent_q;
  logic              s1_is_st;
  logic [DATA_W-1:0] s1_d_or_tag;

  // Stage 1: capture the popped entry and its channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_ent_q   <= '0;
    end else begin
      s1_valid_q <= gnt_valid;
      if (gnt_valid) begin
        s1_ch_q  <= gnt_idx;
        s1_ent_q <= head[gnt_idx];
      end
    end
  end

  assign s1_is_st = s1_ent_q[ENT_W-1];

  // Stores pass data through; loads carry {zero-pad, subtag, ch_id}
  always_comb begin
    s1_d_or_tag = '0;
    if (s1_is_st) begin
      s1_d_or_tag = s1_ent_q[SUB_TAG_W +: DATA_W];
    end else begin
      s1_d_or_tag[CH_ID_LSB +: CH_W]       = s1_ch_q;
      s1_d_or_tag[SUBTAG_LSB +: SUB_TAG_W] = s1_ent_q[SUB_TAG_W-1:0];
    end
  end

  // Output register: one-cycle strobe per entry, addr/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
      req_mem_addr     <= '0;
      req_mem_d_or_tag <= '0;
    end else begin
      req_mem_ld <= s1_valid_q && !s1_is_st;
      req_mem_st <= s1_valid_q && s1_is_st;
      if (s1_valid_q) begin
        req_mem_addr     <= s1_ent_q[ENT_W-2 -: ADDR_W];
        req_mem_d_or_tag <= s1_d_or_tag;
      end
    end
  end

  logic [CH_W-1:0]   rsp_ch;
  logic              rsp_in_range;
  logic [NUM_CH-1:0] rsp_onehot;

  assign rsp_ch       = rsp_mem_tag[CH_ID_LSB +: CH_W];
  assign rsp_in_range = (32'(rsp_ch) < NUM_CH);
  assign rsp_onehot   = {{(NUM_CH-1){1'b0}}, 1'b1} << rsp_ch;

  // Response routing, fixed one-cycle latency; out-of-range ids are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_rsp_push   <= '0;
      ch_rsp_subtag <= '0;
      ch_rsp_q      <= '0;
    end else begin
      ch_rsp_push <= (rsp_mem_push && rsp_in_range) ? rsp_onehot : '0;
      if (rsp_mem_push && rsp_in_range) begin
        ch_rsp_subtag <= rsp_mem_tag[SUBTAG_LSB +: SUB_TAG_W];
        ch_rsp_q      <= rsp_mem_q;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      err[ERR_FULL] <= err[ERR_FULL] | (|drop);
      err[ERR_TAG]  <= err[ERR_TAG] | (rsp_mem_push && !rsp_in_range);
    end
  end

  assign busy = (|nonempty) | s1_valid_q | req_mem_ld | req_mem_st;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter: a transaction-level model of the
// channel queues and arbitration rule predicts every memory strobe and
// response; a monitor process compares them as the DUT presents them.
module tb_spmv_mem_arbiter;

  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 48;
  localparam int DATA_W     = 64;
  localparam int SUB_TAG_W  = 2;
  localparam int FIFO_DEPTH = 32;
  localparam int AF_MARGIN  = 4;
  localparam int CH_W       = 2;
  localparam int TAG_W      = SUB_TAG_W + CH_W;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_CH-1:0]             ch_req_ld = '0, ch_req_st = '0;
  logic [NUM_CH*ADDR_W-1:0]      ch_req_addr = '0;
  logic [NUM_CH*DATA_W-1:0]      ch_req_d = '0;
  logic [NUM_CH*SUB_TAG_W-1:0]   ch_req_subtag = '0;
  logic [NUM_CH-1:0]             ch_req_almost_full;
  logic                          req_mem_ld, req_mem_st;
  logic [ADDR_W-1:0]             req_mem_addr;
  logic [DATA_W-1:0]             req_mem_d_or_tag;
  logic                          req_mem_stall = 1'b0;
  logic                          rsp_mem_push = 1'b0;
  logic [TAG_W-1:0]              rsp_mem_tag = '0;
  logic [DATA_W-1:0]             rsp_mem_q = '0;
  logic [NUM_CH-1:0]             ch_rsp_push;
  logic [SUB_TAG_W-1:0]          ch_rsp_subtag;
  logic [DATA_W-1:0]             ch_rsp_q;
  logic                          busy;
  logic [1:0]                    err;

  spmv_mem_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUB_TAG_W(SUB_TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req_ld(ch_req_ld), .ch_req_st(ch_req_st), .ch_req_addr(ch_req_addr),
    .ch_req_d(ch_req_d), .ch_req_subtag(ch_req_subtag), .ch_req_almost_full(ch_req_almost_full),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .ch_rsp_push(ch_rsp_push), .ch_rsp_subtag(ch_rsp_subtag), .ch_rsp_q(ch_rsp_q),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 is_st;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
    logic [SUB_TAG_W-1:0] sub;
  } req_t;
  typedef struct {
    logic              is_st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dtag;
    int                due;
  } mexp_t;
  typedef struct {
    logic [NUM_CH-1:0]    onehot;
    logic [SUB_TAG_W-1:0] sub;
    logic [DATA_W-1:0]    q;
    int                   due;
  } rexp_t;

  req_t  mq [NUM_CH][$];
  mexp_t exp_req[$];
  rexp_t exp_rsp[$];
  logic [1:0] m_err = '0;
  int m_last = NUM_CH - 1;
  int cyc = 0;
  int strobes = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration rule: next non-empty channel
  function automatic int pick();
`ifdef SPMV_MEM_ARB_RR_EN
    for (int off = 1; off <= NUM_CH; off++) begin
      int c;
      c = (m_last + off) % NUM_CH;
      if (mq[c].size() > 0) return c;
    end
`else
    for (int c = 0; c < NUM_CH; c++) if (mq[c].size() > 0) return c;
`endif
    return -1;
  endfunction

  // One clock edge of the reference model
  task automatic model_edge();
    bit    acc [NUM_CH];
    int    g;
    int    rc;
    req_t  r;
    mexp_t e;
    rexp_t x;
    g = req_mem_stall ? -1 : pick();
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c] = 1'b0;
      if (ch_req_ld[c] || ch_req_st[c]) begin
        if (mq[c].size() >= FIFO_DEPTH) m_err[0] = 1'b1;
        else acc[c] = 1'b1;
      end
    end
    if (g >= 0) begin
      r = mq[g].pop_front();
      m_last = g;
      e.is_st = r.is_st;
      e.addr  = r.addr;
      e.dtag  = r.is_st ? r.data : {{(DATA_W-TAG_W){1'b0}}, r.sub, CH_W'(g)};
      e.due   = cyc + 1;
      exp_req.push_back(e);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc[c]) begin
        r.is_st = ch_req_st[c];
        r.addr  = ch_req_addr[c*ADDR_W +: ADDR_W];
        r.data  = ch_req_d[c*DATA_W +: DATA_W];
        r.sub   = ch_req_subtag[c*SUB_TAG_W +: SUB_TAG_W];
        mq[c].push_back(r);
      end
    end
    if (rsp_mem_push) begin
      rc = int'(rsp_mem_tag[CH_W-1:0]);
      if (rc >= NUM_CH) begin
        m_err[1] = 1'b1;
      end else begin
        x.onehot = NUM_CH'(1) << rc;
        x.sub    = rsp_mem_tag[TAG_W-1:CH_W];
        x.q      = rsp_mem_q;
        x.due    = cyc;
        exp_rsp.push_back(x);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) model_edge();
    end
  end

  task automatic monitor_cycle();
    logic [NUM_CH-1:0] af_exp;
    logic              any_q;
    mexp_t             e;
    rexp_t             x;
    any_q = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      af_exp[c] = (mq[c].size() >= FIFO_DEPTH - AF_MARGIN);
      if (mq[c].size() > 0) any_q = 1'b1;
    end
    chk("almost_full", ch_req_almost_full, af_exp);
    chk("busy", busy, any_q || (exp_req.size() > 0));
    chk("err", err, m_err);
    if (req_mem_ld || req_mem_st) begin
      strobes++;
      if (exp_req.size() == 0) begin
        chk("req_unexpected", {req_mem_ld, req_mem_st}, 2'b00);
      end else begin
        e = exp_req.pop_front();
        chk("req_ld", req_mem_ld, !e.is_st);
        chk("req_st", req_mem_st, e.is_st);
        chk("req_addr", req_mem_addr, e.addr);
        chk("req_d_or_tag", req_mem_d_or_tag, e.dtag);
        chk("req_time", cyc, e.due);
      end
    end else if (exp_req.size() > 0 && exp_req[0].due <= cyc) begin
      e = exp_req.pop_front();
      chk("req_missing", {req_mem_ld, req_mem_st}, {!e.is_st, e.is_st});
    end
    if (ch_rsp_push != '0) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", ch_rsp_push, '0);
      end else begin
        x = exp_rsp.pop_front();
        chk("rsp_push", ch_rsp_push, x.onehot);
        chk("rsp_subtag", ch_rsp_subtag, x.sub);
        chk("rsp_q", ch_rsp_q, x.q);
        chk("rsp_time", cyc, x.due);
      end
    end else if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
      x = exp_rsp.pop_front();
      chk("rsp_missing", ch_rsp_push, x.onehot);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) monitor_cycle();
    end
  end

  task automatic next();
    @(negedge clk);
    ch_req_ld    = '0;
    ch_req_st    = '0;
    rsp_mem_push = 1'b0;
  endtask

  task automatic set_push(input int c, input bit st, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [SUB_TAG_W-1:0] s);
    if (st) ch_req_st[c] = 1'b1;
    else ch_req_ld[c] = 1'b1;
    ch_req_addr[c*ADDR_W +: ADDR_W]         = a;
    ch_req_d[c*DATA_W +: DATA_W]            = d;
    ch_req_subtag[c*SUB_TAG_W +: SUB_TAG_W] = s;
  endtask

  task automatic rand_push(input int c);
    set_push(c, 1'($urandom_range(0, 1)), ADDR_W'({$urandom, $urandom}),
             {$urandom, $urandom}, SUB_TAG_W'($urandom_range(0, 3)));
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    next();
    while ((busy || exp_req.size() > 0 || exp_rsp.size() > 0) && n < maxc) begin
      next();
      n++;
    end
    chk("drain_in_time", n < maxc, 1'b1);
  endtask

  // Called at a negedge; asserts reset, checks outputs cleared at once
  task automatic do_reset();
    #1;
    rst = 1'b1;
    ch_req_ld = '0;
    ch_req_st = '0;
    rsp_mem_push = 1'b0;
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    exp_req.delete();
    exp_rsp.delete();
    m_err  = '0;
    m_last = NUM_CH - 1;
    #1;
    chk("rst_strobes", {req_mem_ld, req_mem_st}, 2'b00);
    chk("rst_addr", req_mem_addr, '0);
    chk("rst_d_or_tag", req_mem_d_or_tag, '0);
    chk("rst_rsp", {ch_rsp_push, ch_rsp_subtag, ch_rsp_q}, '0);
    chk("rst_busy_err_af", {busy, err, ch_req_almost_full}, '0);
    repeat (2) next();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, s1, s_start;
    next();
    do_reset();

    // Single load on ch1: strobe visible after the third edge
    next();
    set_push(1, 1'b0, 48'h1000, 64'h0, 2'd2);
    repeat (3) next();
    #1;
    chk("single_ld_strobe", {req_mem_ld, req_mem_st}, 2'b10);
    chk("single_ld_addr", req_mem_addr, 48'h1000);
    chk("single_ld_tag", req_mem_d_or_tag[3:0], 4'b1001);
    next();
    #1;
    chk("single_ld_one_cycle", req_mem_ld, 1'b0);
    drain(50);

    // All channels push four entries each, no stall
    for (int k = 0; k < 4; k++) begin
      next();
      for (int c = 0; c < NUM_CH; c++) rand_push(c);
    end
    drain(100);

    // Stall mid-stream: at most two strobes skid out, nothing lost
    s_start = strobes;
    for (int k = 0; k < 4; k++) begin
      next();
      for (int c = 0; c < NUM_CH; c++) rand_push(c);
    end
    repeat (2) next();
    req_mem_stall = 1'b1;
    #1;
    s0 = strobes;
    repeat (10) next();
    #1;
    s1 = strobes;
    chk("stall_skid_le2", (s1 - s0) <= 2, 1'b1);
    req_mem_stall = 1'b0;
    drain(100);
    chk("stall_total", strobes - s_start, 12);

    // Fill ch2 while stalled: almost-full from the 28th, 33rd push overflows
    req_mem_stall = 1'b1;
    s_start = strobes;
    for (int k = 1; k <= 33; k++) begin
      next();
      #1;
      if (k == 28) chk("af_before_28th", ch_req_almost_full[2], 1'b0);
      if (k == 29) chk("af_after_28th", ch_req_almost_full[2], 1'b1);
      if (k == 33) chk("no_err_at_32", err[0], 1'b0);
      rand_push(2);
    end
    next();
    #1;
    chk("overflow_err", err[0], 1'b1);
    req_mem_stall = 1'b0;
    drain(200);
    chk("fill_issued", strobes - s_start, 32);

    // Responses: valid route, then out-of-range channel id
    next();
    rsp_mem_push = 1'b1;
    rsp_mem_tag  = 4'b1110;
    rsp_mem_q    = 64'hDEAD;
    next();
    #1;
    chk("rsp_ch2_push", ch_rsp_push, 3'b100);
    chk("rsp_ch2_subtag", ch_rsp_subtag, 2'd3);
    chk("rsp_ch2_q", ch_rsp_q, 64'hDEAD);
    rsp_mem_push = 1'b1;
    rsp_mem_tag  = 4'b0011;
    rsp_mem_q    = 64'hBEEF;
    next();
    #1;
    chk("rsp_bad_no_push", ch_rsp_push, 3'b000);
    chk("rsp_bad_err", err[1], 1'b1);

    // Randomized traffic with stalls and responses
    for (int k = 0; k < 400; k++) begin
      next();
      req_mem_stall = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 9) < 3) rand_push(c);
      if ($urandom_range(0, 2) == 0) begin
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = TAG_W'($urandom_range(0, 15));
        rsp_mem_q    = {$urandom, $urandom};
      end
    end
    req_mem_stall = 1'b0;
    drain(300);

    // Reset with requests queued and one in the output register
    req_mem_stall = 1'b1;
    next();
    for (int c = 0; c < NUM_CH; c++) rand_push(c);
    next();
    rand_push(0);
    rand_push(1);
    next();
    req_mem_stall = 1'b0;
    next();
    req_mem_stall = 1'b1;
    next();
    #1;
    chk("busy_before_rst", busy, 1'b1);
    do_reset();
    req_mem_stall = 1'b0;
    s0 = strobes;
    repeat (10) next();
    #1;
    chk("post_rst_strobes", strobes - s0, 0);
    chk("post_rst_busy", busy, 1'b0);
    chk("leftover_req", exp_req.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
